// File: rtl/led_matrix_scan_pkg.sv
// Shared definitions for the LED matrix scanner.
// Holds the board geometry, the colour codes used by the game controller,
// the scan state encoding, and a helper that locates one cell in the
// packed snapshot.
package led_matrix_scan_pkg;

    localparam int NUM_COLS  = 4;
    localparam int NUM_ROWS  = 8;
    localparam int CELL_BITS = 3;
    localparam int ROW_W     = 3;
    localparam int COL_BITS  = NUM_ROWS * CELL_BITS;
    localparam int SNAP_BITS = NUM_COLS * COL_BITS;

    // Each cell is {R,G,B}
    typedef enum logic [CELL_BITS-1:0] {
        BLACK = 3'b000,
        BLUE  = 3'b001,
        GREEN = 3'b010,
        RED   = 3'b100,
        WHITE = 3'b111
    } colour_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Column x occupies snapshot bits [x*24 +: 24]. Inside a column, row 0
    // sits in the top bits, so row y starts (7-y) cells above the column LSB.
    function automatic int cell_lsb(input int x, input int y);
        return x * COL_BITS + (NUM_ROWS - 1 - y) * CELL_BITS;
    endfunction

endpackage

// File: rtl/led_matrix_scan_scan_row_mux.sv
// scan_row_mux: combinational row selector.
// Ports:
//   i_snap  packed 4x8 snapshot, {column_3, column_2, column_1, column_0}
//   i_row   row index to extract
//   o_r/o_g/o_b  colour bits of that row, bit x is column x
module scan_row_mux
    import led_matrix_scan_pkg::*;
(
    input  logic [SNAP_BITS-1:0] i_snap,
    input  logic [ROW_W-1:0]     i_row,
    output logic [NUM_COLS-1:0]  o_r,
    output logic [NUM_COLS-1:0]  o_g,
    output logic [NUM_COLS-1:0]  o_b
);

    always_comb begin
        o_r = '0;
        o_g = '0;
        o_b = '0;
        for (int x = 0; x < NUM_COLS; x++) begin
            o_r[x] = i_snap[cell_lsb(x, int'(i_row)) + 2];
            o_g[x] = i_snap[cell_lsb(x, int'(i_row)) + 1];
            o_b[x] = i_snap[cell_lsb(x, int'(i_row))];
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: snapshots the 4x8 colour board once per frame and scans
// it row by row onto a common-row RGB matrix, with a blanking gap before
// each row.
// Ports:
//   CLK_50M, RST (sync, active high), enable (0 blanks the matrix)
//   column_0..3  board columns, row 0 in bits [23:21], cell = {R,G,B}
//   row_sel      one-hot row drive, polarity set by ROW_ACTIVE_LOW
//   led_r/g/b    column drives, bit x is column x, active high
//   scan_row     current row index
//   frame_start  one-cycle pulse when a new snapshot is taken
//
// state | meaning
// IDLE  | display disabled, all outputs off
// BLANK | gap before a row, all outputs off, BLANK_TICKS cycles
// SHOW  | row scan_row lit from the snapshot, ROW_TICKS cycles
module led_matrix_scan
    import led_matrix_scan_pkg::*;
#(
    parameter int ROW_TICKS      = 50000,
    parameter int BLANK_TICKS    = 500,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic                 CLK_50M,
    input  logic                 RST,
    input  logic                 enable,
    input  logic [COL_BITS-1:0]  column_0,
    input  logic [COL_BITS-1:0]  column_1,
    input  logic [COL_BITS-1:0]  column_2,
    input  logic [COL_BITS-1:0]  column_3,
    output logic [NUM_ROWS-1:0]  row_sel,
    output logic [NUM_COLS-1:0]  led_r,
    output logic [NUM_COLS-1:0]  led_g,
    output logic [NUM_COLS-1:0]  led_b,
    output logic [ROW_W-1:0]     scan_row,
    output logic                 frame_start
);

    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0]    ROW_LAST   = CNT_W'(ROW_TICKS - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [NUM_ROWS-1:0] ROWS_OFF   = ROW_ACTIVE_LOW ? '1 : '0;
    localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(NUM_ROWS - 1);

    scan_state_t            r_state, w_state_n;
    logic [CNT_W-1:0]       r_cnt, w_cnt_n;
    logic [ROW_W-1:0]       r_row, w_row_n;
    logic [SNAP_BITS-1:0]   r_snap;
    logic                   w_latch;
    logic                   w_fs_n;
    logic [NUM_ROWS-1:0]    w_row_sel_n, w_onehot;
    logic [NUM_COLS-1:0]    w_mux_r, w_mux_g, w_mux_b;
    logic [NUM_COLS-1:0]    w_led_r_n, w_led_g_n, w_led_b_n;
    logic [SNAP_BITS-1:0]   w_frame;

    logic [NUM_ROWS-1:0]    r_row_sel;
    logic [NUM_COLS-1:0]    r_led_r, r_led_g, r_led_b;
    logic                   r_fs;

    assign w_frame = {column_3, column_2, column_1, column_0};

    // Outputs are registered but must be valid on the first SHOW cycle, so
    // the mux looks at the row we are about to enter. The snapshot only
    // changes on entry to BLANK, so the current snapshot is the right one.
    scan_row_mux u_mux (
        .i_snap (r_snap),
        .i_row  (w_row_n),
        .o_r    (w_mux_r),
        .o_g    (w_mux_g),
        .o_b    (w_mux_b)
    );

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + CNT_W'(1);
        w_row_n   = r_row;
        w_latch   = 1'b0;
        w_fs_n    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (enable) begin
                    w_state_n = BLANK;
                    w_row_n   = '0;
                    w_latch   = 1'b1;
                    w_fs_n    = 1'b1;
                end
            end
            BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_n = SHOW;
                    w_cnt_n   = '0;
                end
            end
            SHOW: begin
                if (r_cnt == ROW_LAST) begin
                    w_state_n = BLANK;
                    w_cnt_n   = '0;
                    if (r_row == LAST_ROW) begin
                        w_row_n = '0;
                        w_latch = 1'b1;
                        w_fs_n  = 1'b1;
                    end else begin
                        w_row_n = r_row + ROW_W'(1);
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
                w_row_n   = '0;
            end
        endcase
        if (!enable) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
            w_row_n   = '0;
            w_latch   = 1'b0;
            w_fs_n    = 1'b0;
        end
    end

    always_comb begin
        w_onehot    = NUM_ROWS'(1) << w_row_n;
        w_row_sel_n = ROWS_OFF;
        w_led_r_n   = '0;
        w_led_g_n   = '0;
        w_led_b_n   = '0;
        if (w_state_n == SHOW) begin
            w_row_sel_n = ROW_ACTIVE_LOW ? ~w_onehot : w_onehot;
            w_led_r_n   = w_mux_r;
            w_led_g_n   = w_mux_g;
            w_led_b_n   = w_mux_b;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_row     <= '0;
            r_snap    <= '0;
            r_row_sel <= ROWS_OFF;
            r_led_r   <= '0;
            r_led_g   <= '0;
            r_led_b   <= '0;
            r_fs      <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_row     <= w_row_n;
            if (w_latch) begin
                r_snap <= w_frame;
            end
            r_row_sel <= w_row_sel_n;
            r_led_r   <= w_led_r_n;
            r_led_g   <= w_led_g_n;
            r_led_b   <= w_led_b_n;
            r_fs      <= w_fs_n;
        end
    end

    assign row_sel     = r_row_sel;
    assign led_r       = r_led_r;
    assign led_g       = r_led_g;
    assign led_b       = r_led_b;
    assign scan_row    = r_row;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_led_matrix_scan.sv
module tb_led_matrix_scan;

    localparam int RT = 4;
    localparam int BT = 2;
    localparam int RP = RT + BT;
    localparam int FP = 8 * RP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [23:0] col [4];
    logic [7:0]  row_sel;
    logic [3:0]  led_r, led_g, led_b;
    logic [2:0]  scan_row;
    logic        frame_start;

    always #5 clk = ~clk;

    led_matrix_scan #(.ROW_TICKS(RT), .BLANK_TICKS(BT), .ROW_ACTIVE_LOW(1'b1)) dut (
        .CLK_50M     (clk),
        .RST         (rst),
        .enable      (en),
        .column_0    (col[0]),
        .column_1    (col[1]),
        .column_2    (col[2]),
        .column_3    (col[3]),
        .row_sel     (row_sel),
        .led_r       (led_r),
        .led_g       (led_g),
        .led_b       (led_b),
        .scan_row    (scan_row),
        .frame_start (frame_start)
    );

    wire [23:0] obs = {row_sel, led_r, led_g, led_b, scan_row, frame_start};
    localparam logic [23:0] RESET_VEC = 24'hFF0000;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: position within the frame in cycles since frame_start
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [2:0] m_cell [4][8];

    task automatic model_latch();
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 8; y++)
                m_cell[x][y] = col[x][(7 - y) * 3 +: 3];
    endtask

    task automatic model_edge();
        if (rst) begin
            m_active = 1'b0;
            m_t = 0;
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 8; y++)
                    m_cell[x][y] = 3'b000;
        end else if (!en) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t = 0;
            model_latch();
        end else begin
            m_t++;
            if (m_t == FP) begin
                m_t = 0;
                model_latch();
            end
        end
    endtask

    function automatic logic [23:0] model_out();
        logic [7:0] rs;
        logic [3:0] r, g, b;
        int row, ph;
        rs = 8'hFF; r = '0; g = '0; b = '0;
        if (!m_active) return {rs, r, g, b, 3'd0, 1'b0};
        row = m_t / RP;
        ph  = m_t % RP;
        if (ph >= BT) begin
            rs = ~(8'd1 << row);
            for (int x = 0; x < 4; x++) begin
                r[x] = m_cell[x][row][2];
                g[x] = m_cell[x][row][1];
                b[x] = m_cell[x][row][0];
            end
        end
        return {rs, r, g, b, 3'(row), (m_t == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic restart();
        logic [23:0] e;
        en = 1'b0;
        step();
        e = model_out(); n_total++;
        if (obs !== e) $display("FAIL restart_idle got=%h exp=%h", obs, e);
        else n_pass++;
        en = 1'b1;
    endtask

    task automatic run_until(input int t_target, input string name);
        logic [23:0] e;
        for (int i = 0; i < FP + 4; i++) begin
            step();
            e = model_out(); n_total++;
            if (obs !== e) $display("FAIL %s t=%0d got=%h exp=%h", name, m_t, obs, e);
            else n_pass++;
            if (m_active && m_t == t_target) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (obs !== RESET_VEC) $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, RESET_VEC);
            else n_pass++;
        end
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_single_blue();
        logic [23:0] e;
        int fs_cnt = 0;
        col[0] = 24'h200000; col[1] = '0; col[2] = '0; col[3] = '0;
        restart();
        for (int i = 0; i < 2 * FP; i++) begin
            step();
            e = model_out(); n_total++;
            if (obs !== e) $display("FAIL single_blue t=%0d got=%h exp=%h", m_t, obs, e);
            else n_pass++;
            if (frame_start) fs_cnt++;
            if (m_t == BT) begin
                n_total++;
                if ({row_sel, led_r, led_g, led_b} !== {8'hFE, 4'h0, 4'h0, 4'h1})
                    $display("FAIL blue_row0 got=%h exp=%h", {row_sel, led_r, led_g, led_b}, {8'hFE, 12'h001});
                else n_pass++;
            end
        end
        n_total++;
        if (fs_cnt !== 2) $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        else n_pass++;
    endtask

    task automatic test_white_corner();
        logic [23:0] e;
        col[0] = '0; col[3] = 24'h000007;
        restart();
        for (int i = 0; i < FP; i++) begin
            step();
            e = model_out(); n_total++;
            if (obs !== e) $display("FAIL white t=%0d got=%h exp=%h", m_t, obs, e);
            else n_pass++;
            if (m_t == 7 * RP + BT) begin
                n_total++;
                if ({row_sel, led_r, led_g, led_b} !== {8'h7F, 4'h8, 4'h8, 4'h8})
                    $display("FAIL white_row7 got=%h exp=%h", {row_sel, led_r, led_g, led_b}, {8'h7F, 12'h888});
                else n_pass++;
            end
        end
    endtask

    task automatic test_anti_tear();
        logic [23:0] e;
        bit seen_fs = 1'b0;
        col[1] = '0;
        restart();
        run_until(2 * RP + BT + 2, "tear_pre");
        col[1] = 24'hFFFFFF;
        for (int i = 0; i < FP + 40; i++) begin
            step();
            e = model_out(); n_total++;
            if (obs !== e) $display("FAIL tear t=%0d got=%h exp=%h", m_t, obs, e);
            else n_pass++;
            if (frame_start) seen_fs = 1'b1;
            if (row_sel !== 8'hFF) begin
                n_total++;
                if ({led_r[1], led_g[1], led_b[1]} !== (seen_fs ? 3'b111 : 3'b000))
                    $display("FAIL tear_col1 got=%b exp=%b", {led_r[1], led_g[1], led_b[1]}, seen_fs ? 3'b111 : 3'b000);
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [23:0] e;
        restart();
        run_until(3 * RP + BT + 1, "drop_pre");
        en = 1'b0;
        step();
        n_total++;
        if (obs !== RESET_VEC) $display("FAIL enable_drop got=%h exp=%h", obs, RESET_VEC);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            e = model_out(); n_total++;
            if (obs !== e) $display("FAIL drop_idle got=%h exp=%h", obs, e);
            else n_pass++;
        end
        en = 1'b1;
        step();
        n_total++;
        if ({scan_row, frame_start, row_sel} !== {3'd0, 1'b1, 8'hFF})
            $display("FAIL reenable got=%h exp=%h", {scan_row, frame_start, row_sel}, {3'd0, 1'b1, 8'hFF});
        else n_pass++;
        for (int i = 0; i < 2 * RP; i++) begin
            step();
            e = model_out(); n_total++;
            if (obs !== e) $display("FAIL reenable_run t=%0d got=%h exp=%h", m_t, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] e;
        run_until(5 * RP + BT + 1, "rstmid_pre");
        rst = 1'b1;
        step();
        n_total++;
        if (obs !== RESET_VEC) $display("FAIL reset_mid got=%h exp=%h", obs, RESET_VEC);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < FP + 12; i++) begin
            step();
            e = model_out(); n_total++;
            if (obs !== e) $display("FAIL reset_mid_run t=%0d got=%h exp=%h", m_t, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [23:0] e;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) col[$urandom_range(0, 3)] = 24'($urandom);
            en  = ($urandom_range(0, 199) != 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
            e = model_out(); n_total++;
            if (obs !== e) $display("FAIL random cyc=%0d t=%0d got=%h exp=%h", i, m_t, obs, e);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int x = 0; x < 4; x++) col[x] = '0;
        test_reset();
        test_single_blue();
        test_white_corner();
        test_anti_tear();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
